// File: rtl/opaque_elastic_fifo.sv
// ---------------------------------------------------------------------------
// opaque_elastic_fifo
//
// Elastic FIFO with a fully registered output stage. Both the forward
// (valid/data) and the backward (ready) paths are cut, so no input port
// reaches any output port combinationally. The head word lives in the output
// register. Up to DEPTH-1 further words wait in a small circular buffer.
//
// Parameters:
//   DATA_TYPE  data width in bits (>= 1)
//   DEPTH      capacity in words, including the output register (>= 1)
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous, active-high reset
//   ins         input data
//   ins_valid   input valid
//   ins_ready   input ready, high whenever the FIFO is not full
//   outs        output data, straight from a register
//   outs_valid  output valid, straight from a register
//   outs_ready  output ready
//   count       occupancy, including the word presented on outs
// ---------------------------------------------------------------------------
module opaque_elastic_fifo #(
  parameter int DATA_TYPE = 32,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_TYPE-1:0]       ins,
  input  logic                       ins_valid,
  output logic                       ins_ready,
  output logic [DATA_TYPE-1:0]       outs,
  output logic                       outs_valid,
  input  logic                       outs_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int BUF_D = (DEPTH > 1) ? DEPTH - 1 : 1;
  localparam int PTR_W = (BUF_D > 1) ? $clog2(BUF_D) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic                 push;
  logic                 pop;
  logic                 buf_empty;
  logic                 ld_direct;
  logic                 ld_buf;
  logic                 wr_buf;
  logic [DATA_TYPE-1:0] buf_head;

  // ins_ready depends on the registered count only, never on outs_ready.
  assign ins_ready = (count != CNT_FULL);
  assign push      = ins_valid & ins_ready;
  assign pop       = outs_valid & outs_ready;

  // The buffer only holds words behind the head, so it is empty whenever at
  // most one word is stored. For DEPTH=1 this is always true.
  assign buf_empty = (count <= CNT_ONE);

  // A pushed word bypasses the buffer when the output register is free now or
  // frees up on this edge with nothing queued behind it.
  assign ld_direct = push & (~outs_valid | (pop & buf_empty));
  assign ld_buf    = pop & ~buf_empty;
  assign wr_buf    = push & ~ld_direct;

  // ---- circular buffer stage ----
  if (DEPTH > 1) begin : g_buf
    logic [DATA_TYPE-1:0] mem [0:(1<<PTR_W)-1];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(BUF_D - 1)) return '0;
      else                        return p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
      if (wr_buf) mem[wr_ptr] <= ins;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (wr_buf) wr_ptr <= next_ptr(wr_ptr);
        if (ld_buf) rd_ptr <= next_ptr(rd_ptr);
      end
    end

    assign buf_head = mem[rd_ptr];
  end else begin : g_nobuf
    assign buf_head = '0;
  end

  // ---- output register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      outs       <= '0;
      outs_valid <= 1'b0;
    end else if (ld_direct) begin
      outs       <= ins;
      outs_valid <= 1'b1;
    end else if (ld_buf) begin
      outs       <= buf_head;
      outs_valid <= 1'b1;
    end else if (pop) begin
      // Drained with nothing to refill: outs keeps its last value.
      outs_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_opaque_elastic_fifo.sv
module tb_opaque_elastic_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  // Main directed DUT, DEPTH = 4
  logic        rst;
  logic [31:0] m_ins;
  logic        m_iv;
  logic        m_ir;
  logic [31:0] m_outs;
  logic        m_ov;
  logic        m_or;
  logic [2:0]  m_cnt;

  opaque_elastic_fifo #(.DATA_TYPE(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ins(m_ins), .ins_valid(m_iv), .ins_ready(m_ir),
    .outs(m_outs), .outs_valid(m_ov), .outs_ready(m_or), .count(m_cnt)
  );

  // Stress instances, DEPTH = 1..4, each with its own queue model
  logic srst;
  logic stress_go = 1'b0;
  int   done_cnt  = 0;

  for (genvar g = 0; g < 4; g++) begin : g_st
    localparam int D  = g + 1;
    localparam int CW = $clog2(D + 1);
    logic          iv, ordy, ov, irdy;
    logic [31:0]   id, od;
    logic [CW-1:0] cnt;

    opaque_elastic_fifo #(.DATA_TYPE(32), .DEPTH(D)) u_st (
      .clk(clk), .rst(srst), .ins(id), .ins_valid(iv), .ins_ready(irdy),
      .outs(od), .outs_valid(ov), .outs_ready(ordy), .count(cnt)
    );

    initial begin
      logic [31:0] q[$];
      logic [31:0] seq;
      bit          push, pop;
      iv = 1'b0; ordy = 1'b0; id = '0; seq = 32'h1000 * D;
      wait (stress_go);
      for (int c = 0; c < 10000; c++) begin
        @(negedge clk);
        check($sformatf("st%0d_count", D), 64'(cnt), 64'(q.size()));
        check($sformatf("st%0d_valid", D), 64'(ov), 64'(q.size() != 0));
        if (q.size() != 0) check($sformatf("st%0d_data", D), 64'(od), 64'(q[0]));
        check($sformatf("st%0d_ready", D), 64'(irdy), 64'(q.size() != D));
        iv   = 1'($urandom_range(0, 1));
        ordy = 1'($urandom_range(0, 1));
        id   = seq;
        #1 ordy = ~ordy;
        #1 check($sformatf("st%0d_comb", D), 64'(irdy), 64'(q.size() != D));
        ordy = ~ordy;
        push = iv && (q.size() != D);
        pop  = ordy && (q.size() != 0);
        if (pop) void'(q.pop_front());
        if (push) begin
          q.push_back(id);
          seq++;
        end
      end
      @(negedge clk);
      iv = 1'b0; ordy = 1'b0;
      done_cnt++;
    end
  end

  typedef struct {
    logic        r;
    logic        iv;
    logic [31:0] ins;
    logic        ordy;
    logic        e_ov;
    logic [31:0] e_outs;
    logic [2:0]  e_cnt;
    logic        e_ir;
  } vec_t;

  function automatic vec_t mk(input logic r, iv, input logic [31:0] ins, input logic ordy,
                              input logic e_ov, input logic [31:0] e_outs,
                              input logic [2:0] e_cnt, input logic e_ir);
    vec_t v;
    v.r = r; v.iv = iv; v.ins = ins; v.ordy = ordy;
    v.e_ov = e_ov; v.e_outs = e_outs; v.e_cnt = e_cnt; v.e_ir = e_ir;
    return v;
  endfunction

  vec_t vecs[25];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    // rst iv ins ordy | ov outs cnt ir   (state after the edge)
    vecs[0]  = mk(1, 1, 32'hAA, 0, 0, 32'h00, 0, 1);
    vecs[1]  = mk(1, 1, 32'hAA, 0, 0, 32'h00, 0, 1);
    vecs[2]  = mk(0, 0, 32'hAA, 0, 0, 32'h00, 0, 1);
    vecs[3]  = mk(0, 1, 32'h01, 1, 1, 32'h01, 1, 1);
    vecs[4]  = mk(0, 1, 32'h02, 1, 1, 32'h02, 1, 1);
    vecs[5]  = mk(0, 1, 32'h03, 1, 1, 32'h03, 1, 1);
    vecs[6]  = mk(0, 0, 32'h00, 1, 0, 32'h03, 0, 1);
    vecs[7]  = mk(0, 1, 32'h10, 0, 1, 32'h10, 1, 1);
    vecs[8]  = mk(0, 1, 32'h11, 0, 1, 32'h10, 2, 1);
    vecs[9]  = mk(0, 1, 32'h12, 0, 1, 32'h10, 3, 1);
    vecs[10] = mk(0, 1, 32'h13, 0, 1, 32'h10, 4, 0);
    vecs[11] = mk(0, 1, 32'h14, 0, 1, 32'h10, 4, 0);
    vecs[12] = mk(0, 1, 32'h15, 0, 1, 32'h10, 4, 0);
    vecs[13] = mk(0, 1, 32'h14, 1, 1, 32'h11, 3, 1);
    vecs[14] = mk(0, 1, 32'h14, 1, 1, 32'h12, 3, 1);
    vecs[15] = mk(0, 1, 32'h15, 1, 1, 32'h13, 3, 1);
    vecs[16] = mk(0, 0, 32'h00, 1, 1, 32'h14, 2, 1);
    vecs[17] = mk(0, 0, 32'h00, 1, 1, 32'h15, 1, 1);
    vecs[18] = mk(0, 0, 32'h00, 1, 0, 32'h15, 0, 1);
    vecs[19] = mk(0, 1, 32'h20, 0, 1, 32'h20, 1, 1);
    vecs[20] = mk(0, 1, 32'h21, 0, 1, 32'h20, 2, 1);
    vecs[21] = mk(0, 1, 32'h22, 0, 1, 32'h20, 3, 1);
    vecs[22] = mk(1, 1, 32'h99, 1, 0, 32'h00, 0, 1);
    vecs[23] = mk(0, 1, 32'h77, 0, 1, 32'h77, 1, 1);
    vecs[24] = mk(0, 0, 32'h00, 1, 0, 32'h77, 0, 1);

    rst = 1'b0; m_iv = 1'b0; m_ins = '0; m_or = 1'b0;
    srst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) srst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      rst = vecs[i].r; m_iv = vecs[i].iv; m_ins = vecs[i].ins; m_or = vecs[i].ordy;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", i), 64'(m_ov),   64'(vecs[i].e_ov));
      check($sformatf("v%0d_outs", i),  64'(m_outs), 64'(vecs[i].e_outs));
      check($sformatf("v%0d_count", i), 64'(m_cnt),  64'(vecs[i].e_cnt));
      check($sformatf("v%0d_ready", i), 64'(m_ir),   64'(vecs[i].e_ir));
    end

    // Fill to full, then toggle outs_ready mid-cycle: ins_ready must not move.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rst = 1'b0; m_iv = 1'b1; m_ins = 32'hA0 + k; m_or = 1'b0;
      @(posedge clk);
      #1 check($sformatf("fill%0d_count", k), 64'(m_cnt), 64'(k + 1));
    end
    @(negedge clk);
    m_iv = 1'b0;
    #1 check("full_ready_low", 64'(m_ir), 64'(0));
    m_or = 1'b1;
    #1 check("full_ready_comb", 64'(m_ir), 64'(0));
    check("full_head_stable", 64'(m_outs), 64'(32'hA0));

    // Drain with a bounded wait; words must arrive in order, no gaps.
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (m_ov) begin
        check($sformatf("drain%0d_data", got), 64'(m_outs), 64'(32'hA0 + got));
        got++;
      end
      @(posedge clk);
      #1;
    end
    check("drain_words", 64'(got), 64'(4));
    check("drain_empty", 64'(m_ov), 64'(0));
    @(negedge clk) m_or = 1'b0;

    stress_go = 1'b1;
    wait (done_cnt == 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/opaque_elastic_fifo.md
# opaque_elastic_fifo

Registered-output elastic FIFO for the handshake dataflow library, complementing the transparent half buffer: where that buffer cuts only the ready path, this block cuts both the valid/data path and the ready path. No input port reaches any output port combinationally. Storage is DEPTH words. Buffer placement inserts it on channels that need a full register slice plus slack, typically at loop back-edges and long inter-unit channels.

## Interface
- DATA_TYPE, 32, data width in bits (≥1)
- DEPTH, 4, capacity in words (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- ins  in  DATA_TYPE  input data
- ins_valid  in  1  input valid
- ins_ready  out  1  input ready
- outs  out  DATA_TYPE  output data, driven directly by a register
- outs_valid  out  1  output valid, driven directly by a register
- outs_ready  in  1  output ready
- count  out  $clog2(DEPTH+1)  current occupancy, including the word presented on outs

## Operation
- Push: ins_valid & ins_ready at a rising edge. Pop: outs_valid & outs_ready at a rising edge.
- ins_ready = (count != DEPTH). It is a function of registered state only and has no path from outs_ready.
- Head word sits in an output register (outs, outs_valid). Remaining words sit in a circular buffer of DEPTH-1 entries with rd/wr pointers that wrap modulo DEPTH-1. For DEPTH=1, only the output register exists.
- Push when the output register is empty, or is being popped while the circular buffer is empty: the word goes directly to the output register.
- Push otherwise: the word is written at wr_ptr, then wr_ptr advances.
- Pop with the circular buffer non-empty: the output register loads the entry at rd_ptr, then rd_ptr advances.
- Pop with the circular buffer empty and no push: outs_valid ← 0. outs retains its last value.
- Simultaneous push and pop: count unchanged; both operations take effect in the same edge.
- Full (count = DEPTH): ins_ready = 0, even if outs_ready = 1 in the same cycle. A pop makes ins_ready rise one cycle later.
- Empty (count = 0): outs_valid = 0 and outs_ready is ignored.
- Order is strictly FIFO. Data is never dropped or duplicated.
- While outs_valid = 1 and outs_ready = 0, outs and outs_valid hold stable.
- count: +1 on push only, −1 on pop only, otherwise unchanged. It never exceeds DEPTH.

## Timing
- Reset values (edge with rst = 1): outs_valid = 0, outs = 0, count = 0, pointers = 0. Consequently ins_ready = 1 from the first cycle after reset.
- Reset mid-operation: all stored words are discarded. Handshakes in the reset cycle have no effect.
- Latency: a word pushed into an empty FIFO at edge t is valid on outs during cycle t+1.
- A word pushed behind N stored words appears after N pops.
- Throughput:
  - DEPTH ≥ 2: one word per cycle sustained.
  - DEPTH = 1: one word per two cycles, since ins_ready is low whenever the single slot is occupied.
- count and ins_ready update in the cycle after the causing edge.
- All state updates occur on the rising edge of clk only.

## Test plan
- Reset/idle: assert rst for 2 cycles with ins_valid = 1, ins = 0xAA → afterwards outs_valid = 0, count = 0, ins_ready = 1, and 0xAA never appears on outs.
- Latency and streaming (DEPTH = 4): outs_ready held 1; push 0x01, 0x02, 0x03 on consecutive edges → outs shows 0x01, 0x02, 0x03 in cycles t+1, t+2, t+3. count stays at 1 throughout.
- Fill and backpressure (DEPTH = 4): outs_ready = 0; push 0x10..0x15 with ins_valid held high → only 0x10..0x13 are accepted, count = 4, and ins_ready = 0 from the cycle after the 4th push. outs holds 0x10 stable.
- Drain and wrap: from the full state, set outs_ready = 1 and continue pushing 0x14, 0x15 → outs sequence is 0x10, 0x11, 0x12, 0x13, 0x14, 0x15 with no gaps or repeats, and ins_ready returns to 1 one cycle after the first pop.
- Random stress: 10,000 cycles with random ins_valid/outs_ready at 50% each, DEPTH ∈ {1, 2, 3, 4} → scoreboard order matches exactly. Check also:
  - count equals the model occupancy every cycle.
  - outs is stable under stall.
  - No combinational dependence: toggling outs_ready mid-cycle leaves ins_ready unchanged.
- Reset mid-stream: with count = 3, pulse rst for 1 cycle → count = 0 and outs_valid = 0; the next pushed value 0x77 appears at latency 1.
